// File: rtl/serial_tx_if.sv
// serial_tx_if: producer handshake and serial line outputs of serial_tx
interface serial_tx_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             tx;
  logic             busy;
  logic             done;
  modport master (output in_valid, in_data, input in_ready, tx, busy, done);
  modport slave  (input in_valid, in_data, output in_ready, tx, busy, done);
endinterface

// File: rtl/serial_tx.sv
// serial_tx: start/data/stop serial transmitter, LSB first, all outputs registered
module serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  serial_tx_if.slave   bus
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             tx_q, tx_d, busy_q, busy_d, done_q, done_d, in_ready_q, in_ready_d;
  logic             bit_end;
  assign bit_end = cnt_q == '0;
  // next state, bit-period/bit-index bookkeeping and registered output values
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? CNT_LOAD : cnt_q - 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (in_ready_q && bus.in_valid) begin
          state_d = START;
          cnt_d   = CNT_LOAD;
          idx_d   = '0;
          shift_d = bus.in_data;
        end
      end
      START: state_d = bit_end ? DATA : START;
      DATA: if (bit_end) begin
        if (idx_q == IDX_LAST) state_d = STOP;
        else begin
          idx_d   = idx_q + 1'b1;
          shift_d = shift_q >> 1;
        end
      end
      STOP: if (bit_end) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    tx_d       = (state_d == DATA) ? shift_d[0] : (state_d != START);
    busy_d     = state_d != IDLE;
    in_ready_d = state_d == IDLE;
  end
  // state and output registers; reset drops any frame in progress
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end
  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.in_ready = in_ready_q;
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed checks of serial_tx framing, handshake and reset
module tb_serial_tx;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   t_done = 0;
  int   t1 = 0;
  int   t2 = 0;
  serial_tx_if #(.WIDTH(8)) a ();
  serial_tx_if #(.WIDTH(8)) b ();
  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut_a (.clk(clk), .reset(reset), .bus(a.slave));
  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut_b (.clk(clk), .reset(reset), .bus(b.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask
  function automatic logic fbit(input logic [7:0] d, input int k);
    return (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d[k-1];
  endfunction
  task automatic accept(input logic [7:0] d);
    a.in_data  = d;
    a.in_valid = 1'b1;
    tick();
    a.in_valid = 1'b0;
  endtask
  task automatic frame_a(input logic [7:0] d);
    for (int k = 0; k < 40; k++) begin
      chk("frame_tx", a.tx, fbit(d, k / 4));
      chk("frame_busy", a.busy, 1'b1);
      chk("frame_ready", a.in_ready, 1'b0);
      chk("frame_done", a.done, 1'b0);
      tick();
    end
    chk("done_pulse", a.done, 1'b1);
    chk("done_busy", a.busy, 1'b0);
    chk("done_tx", a.tx, 1'b1);
    chk("done_ready", a.in_ready, 1'b1);
    t_done = cyc;
  endtask
  initial begin
    reset      = 1'b0;
    a.in_valid = 1'b0;
    a.in_data  = '0;
    b.in_valid = 1'b0;
    b.in_data  = '0;
    tick();
    tick();
    chk("rst_ready", a.in_ready, 1'b0);
    chk("rst_tx", a.tx, 1'b1);
    chk("rst_busy", a.busy, 1'b0);
    reset = 1'b1;
    tick();
    chk("rel_tx", a.tx, 1'b1);
    chk("rel_busy", a.busy, 1'b0);
    chk("rel_done", a.done, 1'b0);
    chk("rel_ready", a.in_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_tx", a.tx, 1'b1);
      chk("idle_busy", a.busy, 1'b0);
      chk("idle_done", a.done, 1'b0);
    end
    accept(8'hA5);
    frame_a(8'hA5);
    tick();
    chk("post_done", a.done, 1'b0);
    chk("post_tx", a.tx, 1'b1);
    a.in_data  = 8'h3C;
    a.in_valid = 1'b1;
    tick();
    a.in_data  = 8'hFF;
    frame_a(8'h3C);
    tick();
    a.in_valid = 1'b0;
    frame_a(8'hFF);
    accept(8'h01);
    frame_a(8'h01);
    t1 = t_done;
    accept(8'h80);
    frame_a(8'h80);
    t2 = t_done;
    vectors++;
    assert (t2 - t1 === 41) else begin
      miscompares++;
      $error("FAIL b2b_done_gap: observed %0d expected 41", t2 - t1);
    end
    tick();
    chk("b2b_post_done", a.done, 1'b0);
    accept(8'h00);
    for (int k = 0; k < 11; k++) begin
      chk("mid_tx", a.tx, fbit(8'h00, k / 4));
      tick();
    end
    reset = 1'b0;
    tick();
    chk("mid_rst_tx", a.tx, 1'b1);
    chk("mid_rst_busy", a.busy, 1'b0);
    chk("mid_rst_done", a.done, 1'b0);
    reset = 1'b1;
    tick();
    chk("mid_rel_ready", a.in_ready, 1'b1);
    for (int k = 0; k < 45; k++) begin
      chk("mid_no_resume_busy", a.busy, 1'b0);
      chk("mid_no_done", a.done, 1'b0);
      chk("mid_no_resume_tx", a.tx, 1'b1);
      tick();
    end
    reset      = 1'b0;
    a.in_data  = 8'h00;
    a.in_valid = 1'b1;
    tick();
    chk("prio_busy", a.busy, 1'b0);
    chk("prio_tx", a.tx, 1'b1);
    chk("prio_ready", a.in_ready, 1'b0);
    reset      = 1'b1;
    a.in_valid = 1'b0;
    tick();
    chk("prio_rel_busy", a.busy, 1'b0);
    chk("prio_rel_ready", a.in_ready, 1'b1);
    b.in_data  = 8'h55;
    b.in_valid = 1'b1;
    tick();
    b.in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("min_tx", b.tx, fbit(8'h55, k));
      chk("min_busy", b.busy, 1'b1);
      tick();
    end
    chk("min_done", b.done, 1'b1);
    chk("min_idle_busy", b.busy, 1'b0);
    tick();
    chk("min_post_done", b.done, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per frame (range 1-32).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit (minimum 1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-low (asserted when 0, sampled on the rising edge of clk).
REQ-005 SHALL have port in_valid, input, 1 bit: the producer offers in_data.
REQ-006 SHALL have port in_data, input, WIDTH bits: the parallel word to transmit.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 SHALL have port tx, output, 1 bit: the serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 SHALL have port done, output, 1 bit: a one-cycle pulse marking frame completion.

Function
REQ-011 SHALL implement states IDLE, START, DATA and STOP, with all outputs registered.
REQ-012 SHALL accept a word only on a rising edge where in_valid=1 and in_ready=1; in_ready SHALL be 1 only in IDLE.
REQ-013 SHALL latch in_data into an internal shift register on accept; later in_data changes SHALL have no effect on the current frame.
REQ-014 SHALL, on accept, enter START, with tx=0 and busy=1 visible from the cycle after the accepting edge.
REQ-015 SHALL hold each bit (start, each data bit, stop) on tx for exactly CLKS_PER_BIT cycles, using a bit-period counter of width clog2(CLKS_PER_BIT)+1 that reloads at each bit boundary.
REQ-016 SHALL, after START, transmit the WIDTH data bits in DATA, LSB first, using a bit index that counts 0..WIDTH-1 and does not wrap within a frame.
REQ-017 SHALL, after the last data bit, enter STOP with tx=1 for CLKS_PER_BIT cycles.
REQ-018 SHALL make the frame length exactly (WIDTH+2)*CLKS_PER_BIT cycles of busy=1.
REQ-019 SHALL, at the end of STOP, return to IDLE and assert done=1 for exactly one cycle, namely the first IDLE cycle, with in_ready=1 in that same cycle.
REQ-020 SHALL support back-to-back frames: an accept in the done cycle starts the next START on the following cycle, with exactly one idle-high cycle between frames.
REQ-021 SHALL ignore in_valid while busy; the word is neither queued nor lost-flagged, and the producer holds it until in_ready=1.
REQ-022 SHALL hold tx=1, busy=0 and done=0 in IDLE indefinitely when there is no accept.
REQ-023 SHALL, with CLKS_PER_BIT=1, change tx every cycle; no state may last zero cycles.

Reset
REQ-024 SHALL, while reset=0 at a rising edge, force state=IDLE, tx=1, busy=0, done=0 and in_ready=0, and clear the counters and shift register.
REQ-025 SHALL drive in_ready=1 in the first cycle after reset deasserts.
REQ-026 SHALL abandon a frame when reset is asserted mid-frame: tx=1 after the next edge, no done pulse, and no resumption after deassert.
REQ-027 SHALL give reset priority over a simultaneous accept; the word is not taken.

Verification (WIDTH=8, CLKS_PER_BIT=4)
REQ-028 Reset: hold reset=0 for 2 cycles, then release -> tx=1, busy=0, done=0, in_ready=1 in the first cycle after release.
REQ-029 Single frame: accept 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy=1 for 40 cycles; done=1 for exactly 1 cycle afterwards.
REQ-030 Data hold: accept 0x3C, then change in_data to 0xFF and keep in_valid=1 during the frame -> transmitted bits are 0,0,1,1,1,1,0,0; no second accept until the done cycle.
REQ-031 Back-to-back: accept 0x01 and 0x80, each in its done cycle -> frames separated by exactly 1 tx=1 idle cycle; two done pulses 41 cycles apart.
REQ-032 Mid-frame reset: accept 0x00, assert reset at cycle 12 of the frame -> tx=1 and busy=0 on the next cycle, no done pulse, in_ready=1 after release.
REQ-033 Minimum period: CLKS_PER_BIT=1, accept 0x55 -> tx 0,1,0,1,0,1,0,1,0,1 on consecutive cycles; busy=1 for 10 cycles.
